// File: rtl/data_memory_arbiter_pkg.sv
// Shared types and sizing constants for the DataMemory arbiter and PE-side models.
package data_memory_arbiter_pkg;

  localparam int DEF_NUM_REQ       = 4;
  localparam int DEF_ADDRESS_WIDTH = 8;
  localparam int DEF_DATA_WIDTH    = 16;
  localparam int DEF_LOCK_MAX      = 15;

  // Index width that stays at least 1 bit even for degenerate sizes.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int REQ_IDX_WIDTH  = idx_width(DEF_NUM_REQ);
  localparam int LOCK_CNT_WIDTH = idx_width(DEF_LOCK_MAX + 1);

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/data_memory_arbiter_if.sv
// PE load/store request bus, read-response bus and DataMemory port as one bundle.
interface data_memory_arbiter_if #(
  parameter int NUM_REQ       = 4,
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 16
);
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0]               req_write;
  logic [NUM_REQ-1:0]               req_lock;
  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_address;
  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ-1:0]               resp_valid;
  logic [DATA_WIDTH-1:0]            resp_data;
  logic [ADDRESS_WIDTH-1:0]         mem_address;
  logic                             mem_write;
  logic [DATA_WIDTH-1:0]            mem_input_data;
  logic [DATA_WIDTH-1:0]            mem_output_data;

  modport master (
    output req_valid, req_write, req_lock, req_address, req_data, mem_output_data,
    input  req_ready, resp_valid, resp_data, mem_address, mem_write, mem_input_data
  );

  modport slave (
    input  req_valid, req_write, req_lock, req_address, req_data, mem_output_data,
    output req_ready, resp_valid, resp_data, mem_address, mem_write, mem_input_data
  );
endinterface

// File: rtl/data_memory_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_priority_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             found
);
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        idx   = IDX_W'((int'(ptr) + k) % N);
      end
    end
    if (found) grant[idx] = 1'b1;
  end
endmodule

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one single-port DataMemory, 1 op/cycle, reads return
// one cycle after grant; a lock keeps the grant with one PE for up to LOCK_MAX cycles.
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = DEF_NUM_REQ,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int LOCK_MAX      = DEF_LOCK_MAX
) (
  input logic                 clk,
  input logic                 reset_n,
  data_memory_arbiter_if.slave bus
);
  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = idx_width(LOCK_MAX + 1);

  arb_state_t             state, state_nxt;
  logic [IDX_W-1:0]       rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0]       owner, owner_nxt;
  logic [CNT_W-1:0]       lock_cnt, lock_cnt_nxt;
  logic [NUM_REQ-1:0]     pick_grant, ready_vec;
  logic [IDX_W-1:0]       win_idx, grant_idx;
  logic                   pick_found, grant_vld;
  logic                   resp_tag_vld;
  logic [IDX_W-1:0]       resp_tag_idx;
  logic [DATA_WIDTH-1:0]  resp_hold;

  rr_priority_picker #(.N(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (win_idx),
    .found (pick_found)
  );

  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    owner_nxt    = owner;
    lock_cnt_nxt = lock_cnt;
    ready_vec    = '0;
    grant_idx    = '0;
    case (state)
      ARB: begin
        ready_vec = pick_grant;
        grant_idx = win_idx;
        if (pick_found) begin
          rr_ptr_nxt = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
          if (bus.req_lock[win_idx]) begin
            state_nxt    = LOCKED;
            owner_nxt    = win_idx;
            lock_cnt_nxt = CNT_W'(1);
          end
        end
      end
      LOCKED: begin
        ready_vec[owner] = bus.req_valid[owner];
        grant_idx        = owner;
        // The releasing op itself is still granted; the grant returns to ARB next cycle.
        if (!bus.req_valid[owner] || !bus.req_lock[owner] || lock_cnt == CNT_W'(LOCK_MAX)) begin
          state_nxt    = ARB;
          lock_cnt_nxt = '0;
        end else begin
          lock_cnt_nxt = lock_cnt + 1'b1;
        end
      end
      default: state_nxt = ARB;
    endcase
    grant_vld = reset_n && (|ready_vec);
  end

  always_comb begin
    bus.req_ready      = reset_n ? ready_vec : '0;
    bus.mem_write      = 1'b0;
    bus.mem_address    = '0;
    bus.mem_input_data = '0;
    if (grant_vld) begin
      bus.mem_write      = bus.req_write[grant_idx];
      bus.mem_address    = bus.req_address[grant_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      bus.mem_input_data = bus.req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ARB;
      rr_ptr       <= '0;
      owner        <= '0;
      lock_cnt     <= '0;
      resp_tag_vld <= 1'b0;
      resp_tag_idx <= '0;
      resp_hold    <= '0;
    end else begin
      state        <= state_nxt;
      rr_ptr       <= rr_ptr_nxt;
      owner        <= owner_nxt;
      lock_cnt     <= lock_cnt_nxt;
      resp_tag_vld <= grant_vld && !bus.req_write[grant_idx];
      resp_tag_idx <= grant_idx;
      // Memory output may move on idle cycles, so the last read value is kept here.
      if (resp_tag_vld) resp_hold <= bus.mem_output_data;
    end
  end

  always_comb begin
    bus.resp_valid = '0;
    if (resp_tag_vld) bus.resp_valid[resp_tag_idx] = 1'b1;
    bus.resp_data = resp_tag_vld ? bus.mem_output_data : resp_hold;
  end
endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench: DataMemory behind the arbiter, a transaction-level reference model, literal checks.
module tb_data_memory_arbiter;
  logic clk;
  logic reset_n;
  int   n_vec = 0;
  int   n_bad = 0;

  data_memory_arbiter_if #(.NUM_REQ(4), .ADDRESS_WIDTH(8), .DATA_WIDTH(16)) bus ();

  data_memory_arbiter #(.NUM_REQ(4), .ADDRESS_WIDTH(8), .DATA_WIDTH(16), .LOCK_MAX(15)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DataMemory: synchronous read, output held on write, preloaded with 0x1000+addr.
  logic [15:0] dmem [256];
  logic [15:0] dmem_out;
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 16'h1000 + 16'(i);
      dmem_out <= '0;
    end else if (bus.mem_write) begin
      dmem[bus.mem_address] <= bus.mem_input_data;
    end else begin
      dmem_out <= dmem[bus.mem_address];
    end
  end
  assign bus.mem_output_data = dmem_out;

  // Reference model: who may be served this cycle, and what each read must return.
  int          m_ptr, m_owner, m_cnt;
  bit          m_locked;
  bit          p_vld;
  int          p_idx;
  logic [15:0] p_dat, m_last;
  logic [15:0] ref_mem [256];
  int          g_now;

  function automatic int exp_grant();
    if (!reset_n) return -1;
    if (m_locked) return bus.req_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < 4; k++)
      if (bus.req_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  always_comb g_now = exp_grant();

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ptr <= 0; m_owner <= 0; m_cnt <= 0; m_locked <= 1'b0;
      p_vld <= 1'b0; p_idx <= 0; p_dat <= '0; m_last <= '0;
      for (int i = 0; i < 256; i++) ref_mem[i] <= 16'h1000 + 16'(i);
    end else begin
      if (p_vld) m_last <= p_dat;
      p_vld <= 1'b0;
      if (g_now >= 0) begin
        if (bus.req_write[g_now])
          ref_mem[bus.req_address[g_now*8 +: 8]] <= bus.req_data[g_now*16 +: 16];
        else begin
          p_vld <= 1'b1;
          p_idx <= g_now;
          p_dat <= ref_mem[bus.req_address[g_now*8 +: 8]];
        end
      end
      if (!m_locked) begin
        if (g_now >= 0) begin
          m_ptr <= (g_now + 1) % 4;
          if (bus.req_lock[g_now]) begin
            m_locked <= 1'b1; m_owner <= g_now; m_cnt <= 1;
          end
        end
      end else if (g_now < 0 || !bus.req_lock[g_now] || m_cnt == 15) begin
        m_locked <= 1'b0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("req_ready", 32'(bus.req_ready), (g_now < 0) ? 32'h0 : 32'(1 << g_now));
    chk("mem_write", 32'(bus.mem_write), (g_now < 0) ? 32'h0 : 32'(bus.req_write[g_now]));
    chk("mem_address", 32'(bus.mem_address), (g_now < 0) ? 32'h0 : 32'(bus.req_address[g_now*8 +: 8]));
    chk("mem_input_data", 32'(bus.mem_input_data), (g_now < 0) ? 32'h0 : 32'(bus.req_data[g_now*16 +: 16]));
    chk("resp_valid", 32'(bus.resp_valid), p_vld ? 32'(1 << p_idx) : 32'h0);
    chk("resp_data", 32'(bus.resp_data), p_vld ? 32'(p_dat) : 32'(m_last));
  end

  task automatic set_req(input int i, input bit v, input bit w, input bit l,
                         input logic [7:0] a, input logic [15:0] d);
    bus.req_valid[i]          = v;
    bus.req_write[i]          = w;
    bus.req_lock[i]           = l;
    bus.req_address[i*8 +: 8] = a;
    bus.req_data[i*16 +: 16]  = d;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
  endtask

  task automatic all_read();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 1'b0, 8'(i), 16'h0000);
  endtask

  task automatic to_check();
    @(negedge clk); #1;
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0;
    idle_all();
    repeat (3) @(posedge clk);
    to_check();
    chk("rst resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("rst req_ready", 32'(bus.req_ready), 32'h0);
    next_cyc();
    reset_n = 1'b1;

    // Lone req3 with ptr at 0 wins immediately; ptr must wrap back to 0.
    set_req(3, 1'b1, 1'b0, 1'b0, 8'h03, 16'h0000);
    to_check();
    chk("t5 grant req3", 32'(bus.req_ready), 32'h8);
    next_cyc();
    idle_all();
    to_check();
    chk("t5 resp_valid", 32'(bus.resp_valid), 32'h8);
    chk("t5 resp_data", 32'(bus.resp_data), 32'h1003);

    // Locked write/read by req0 while req1..3 wait.
    next_cyc();
    all_read();
    set_req(0, 1'b1, 1'b1, 1'b1, 8'h05, 16'h00A5);
    set_req(1, 1'b1, 1'b0, 1'b0, 8'h11, 16'h0000);
    to_check();
    chk("t3 grant req0 wr", 32'(bus.req_ready), 32'h1);
    chk("t3 mem_address", 32'(bus.mem_address), 32'h5);
    next_cyc();
    set_req(0, 1'b1, 1'b0, 1'b0, 8'h05, 16'h0000);
    to_check();
    chk("t3 lock holds req0", 32'(bus.req_ready), 32'h1);
    next_cyc();
    set_req(0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    to_check();
    chk("t3 grant req1", 32'(bus.req_ready), 32'h2);
    chk("t3 resp_valid", 32'(bus.resp_valid), 32'h1);
    chk("t3 resp_data", 32'(bus.resp_data), 32'h00A5);

    // req2 keeps its lock; the grant must leave it after 16 consecutive ops.
    next_cyc();
    set_req(1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    set_req(2, 1'b1, 1'b0, 1'b1, 8'h02, 16'h0000);
    for (int c = 0; c <= 16; c++) begin
      to_check();
      if (c <= 15) chk("t4 lock req2", 32'(bus.req_ready), 32'h4);
      else         chk("t4 release to req3", 32'(bus.req_ready), 32'h8);
      next_cyc();
    end

    // All four read continuously: grants rotate 0,1,2,3,0.
    all_read();
    for (int c = 0; c < 5; c++) begin
      to_check();
      chk("t2 grant", 32'(bus.req_ready), 32'(1 << (c % 4)));
      if (c > 0) begin
        chk("t2 resp_valid", 32'(bus.resp_valid), 32'(1 << ((c - 1) % 4)));
        chk("t2 resp_data", 32'(bus.resp_data), 32'h1000 + 32'((c - 1) % 4));
      end
      next_cyc();
    end

    // Write then read of the same address by another requester.
    idle_all();
    set_req(1, 1'b1, 1'b1, 1'b0, 8'h07, 16'h003C);
    to_check();
    chk("t6 grant wr req1", 32'(bus.req_ready), 32'h2);
    next_cyc();
    set_req(1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    set_req(2, 1'b1, 1'b0, 1'b0, 8'h07, 16'h0000);
    to_check();
    chk("t6 grant rd req2", 32'(bus.req_ready), 32'h4);
    next_cyc();
    idle_all();
    set_req(0, 1'b1, 1'b1, 1'b0, 8'h20, 16'hFFFF);
    to_check();
    chk("t6 resp_valid", 32'(bus.resp_valid), 32'h4);
    chk("t6 resp_data", 32'(bus.resp_data), 32'h003C);
    next_cyc();
    set_req(0, 1'b1, 1'b1, 1'b0, 8'h21, 16'h1234);
    to_check();
    chk("t6 no resp on wr", 32'(bus.resp_valid), 32'h0);
    chk("t6 resp_data held", 32'(bus.resp_data), 32'h003C);
    next_cyc();
    idle_all();
    to_check();
    chk("t6 resp_data held2", 32'(bus.resp_data), 32'h003C);

    // Reset lands while a read is in flight.
    next_cyc();
    set_req(2, 1'b1, 1'b0, 1'b0, 8'h02, 16'h0000);
    to_check();
    chk("t1 grant req2", 32'(bus.req_ready), 32'h4);
    #1 reset_n = 1'b0;
    #1;
    chk("t1 rst req_ready", 32'(bus.req_ready), 32'h0);
    chk("t1 rst mem_write", 32'(bus.mem_write), 32'h0);
    chk("t1 rst mem_address", 32'(bus.mem_address), 32'h0);
    next_cyc();
    to_check();
    chk("t1 resp killed", 32'(bus.resp_valid), 32'h0);
    next_cyc();
    reset_n = 1'b1;
    all_read();
    to_check();
    chk("t1 ptr back to 0", 32'(bus.req_ready), 32'h1);
    next_cyc();
    idle_all();
    to_check();
    chk("t1 resp after rst", 32'(bus.resp_valid), 32'h1);
    chk("t1 data after rst", 32'(bus.resp_data), 32'h1000);
    next_cyc();
    to_check();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
